// File: rtl/mem_responder.sv
// Byte-wide memory responder: 256-byte store serving CPU read/write in RUN and
// front-panel load/check stepping (key A1, switches D) in LOAD/CHECK.
module mem_responder #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cpustate,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        read,
  input  logic        write,
  input  logic        A1,
  input  logic [7:0]  D,
  output logic [7:0]  data_out,
  output logic [7:0]  check_out,
  output logic [7:0]  ptr_out,
  output logic        oob,
  output logic        conflict
);

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    LOAD  = 2'b01,
    CHECK = 2'b10,
    RUN   = 2'b11
  } mode_e;

  logic [7:0] mem_q [DEPTH];

  logic       a1_s1_q, a1_s2_q, a1_s3_q;
  mode_e      mode, prev_mode_q;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] check_q, check_d;
  logic [7:0] dout_q, dout_d;
  logic       oob_q, oob_d;
  logic       conflict_q, conflict_d;

  logic       step, entry, in_range;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data;

  assign mode      = mode_e'(cpustate);
  assign data_out  = dout_q;
  assign check_out = check_q;
  assign ptr_out   = ptr_q;
  assign oob       = oob_q;
  assign conflict  = conflict_q;

  always_comb begin
    step       = a1_s2_q & ~a1_s3_q;
    // A mode change into LOAD/CHECK rewinds the pointer and swallows a coincident step
    entry      = ((mode == LOAD) || (mode == CHECK)) && (mode != prev_mode_q);
    in_range   = (addr[15:8] == 8'h00);
    ptr_d      = ptr_q;
    check_d    = check_q;
    dout_d     = dout_q;
    oob_d      = oob_q;
    conflict_d = conflict_q;
    wr_en      = 1'b0;
    wr_addr    = ptr_q;
    wr_data    = D;
    case (mode)
      LOAD: begin
        if (entry) begin
          ptr_d = 8'h00;
        end else if (step) begin
          wr_en   = 1'b1;
          check_d = D;
          ptr_d   = ptr_q + 8'd1;
        end
      end
      CHECK: begin
        check_d = mem_q[ptr_q];
        if (entry)     ptr_d = 8'h00;
        else if (step) ptr_d = ptr_q + 8'd1;
      end
      RUN: begin
        wr_addr = addr[7:0];
        wr_data = data_in;
        if (write) begin
          if (in_range) wr_en = 1'b1;
          else          oob_d = 1'b1;
          if (read)     conflict_d = 1'b1;
        end else if (read) begin
          if (in_range) begin
            dout_d = mem_q[addr[7:0]];
          end else begin
            dout_d = 8'h00;
            oob_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1_s1_q     <= 1'b0;
      a1_s2_q     <= 1'b0;
      a1_s3_q     <= 1'b0;
      prev_mode_q <= STOP;
      ptr_q       <= 8'h00;
      check_q     <= 8'h00;
      dout_q      <= 8'h00;
      oob_q       <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      a1_s1_q     <= A1;
      a1_s2_q     <= a1_s1_q;
      a1_s3_q     <= a1_s2_q;
      prev_mode_q <= mode;
      ptr_q       <= ptr_d;
      check_q     <= check_d;
      dout_q      <= dout_d;
      oob_q       <= oob_d;
      conflict_q  <= conflict_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected bytes queued at stimulus time,
// popped and compared when the DUT output is sampled on the falling edge.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cpustate;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        read, write, A1;
  logic [7:0]  D;
  logic [7:0]  data_out, check_out, ptr_out;
  logic        oob, conflict;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_v;

  mem_responder #(.DEPTH(256)) dut (
    .clk(clk), .rst(rst), .cpustate(cpustate), .addr(addr), .data_in(data_in),
    .read(read), .write(write), .A1(A1), .D(D), .data_out(data_out),
    .check_out(check_out), .ptr_out(ptr_out), .oob(oob), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] d);
    D = d; A1 = 1'b1; cyc(3);
    A1 = 1'b0; cyc(3);
  endtask

  task automatic test_reset();
    rst = 1'b0; cpustate = 2'b11; addr = 16'h0010; data_in = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      read = i[0]; write = i[1]; A1 = ~A1; cyc(1);
    end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h want 00", data_out); end
    n_cmp++; if (check_out !== 8'h00) begin n_err++; $display("FAIL rst_check: got %h want 00", check_out); end
    n_cmp++; if (ptr_out !== 8'h00) begin n_err++; $display("FAIL rst_ptr: got %h want 00", ptr_out); end
    n_cmp++; if (oob !== 1'b0) begin n_err++; $display("FAIL rst_oob: got %b want 0", oob); end
    n_cmp++; if (conflict !== 1'b0) begin n_err++; $display("FAIL rst_conflict: got %b want 0", conflict); end
    read = 1'b0; write = 1'b0; A1 = 1'b0; cpustate = 2'b10; cyc(1);
    rst = 1'b1; cyc(3);
    for (int i = 0; i < 256; i++) begin
      sb.push_back(8'h00);
      press(8'h00);
      exp_v = sb.pop_front();
      n_cmp++; if (check_out !== exp_v) begin n_err++; $display("FAIL rst_scan i=%0d: got %h want %h", i, check_out, exp_v); end
      n_cmp++; if (ptr_out !== 8'(i + 1)) begin n_err++; $display("FAIL rst_scan_ptr i=%0d: got %h want %h", i, ptr_out, 8'(i + 1)); end
    end
  endtask

  task automatic test_load_check();
    cpustate = 2'b01; cyc(2);
    sb.push_back(8'hFF);
    press(8'hA5); press(8'h3C); press(8'hFF);
    exp_v = sb.pop_front();
    n_cmp++; if (ptr_out !== 8'd3) begin n_err++; $display("FAIL lc_ptr3: got %h want 03", ptr_out); end
    n_cmp++; if (check_out !== exp_v) begin n_err++; $display("FAIL lc_check: got %h want %h", check_out, exp_v); end
    cpustate = 2'b10; sb.push_back(8'hA5); cyc(3);
    exp_v = sb.pop_front();
    n_cmp++; if (ptr_out !== 8'd0) begin n_err++; $display("FAIL lc_ptr0: got %h want 00", ptr_out); end
    n_cmp++; if (check_out !== exp_v) begin n_err++; $display("FAIL lc_chk0: got %h want %h", check_out, exp_v); end
    sb.push_back(8'h3C); press(8'h00);
    exp_v = sb.pop_front();
    n_cmp++; if (ptr_out !== 8'd1) begin n_err++; $display("FAIL lc_ptr1: got %h want 01", ptr_out); end
    n_cmp++; if (check_out !== exp_v) begin n_err++; $display("FAIL lc_chk1: got %h want %h", check_out, exp_v); end
  endtask

  task automatic test_wrap();
    cpustate = 2'b01; cyc(2);
    for (int i = 0; i < 257; i++) press(8'(i));
    n_cmp++; if (ptr_out !== 8'd1) begin n_err++; $display("FAIL wrap_ptr: got %h want 01", ptr_out); end
    n_cmp++; if (check_out !== 8'h00) begin n_err++; $display("FAIL wrap_load_chk: got %h want 00", check_out); end
    cpustate = 2'b10; sb.push_back(8'h00); cyc(3);
    exp_v = sb.pop_front();
    n_cmp++; if (check_out !== exp_v) begin n_err++; $display("FAIL wrap_mem0: got %h want %h", check_out, exp_v); end
    for (int i = 1; i < 256; i++) begin
      sb.push_back(8'(i));
      press(8'h00);
      exp_v = sb.pop_front();
      n_cmp++; if (check_out !== exp_v) begin n_err++; $display("FAIL wrap_scan i=%0d: got %h want %h", i, check_out, exp_v); end
    end
    n_cmp++; if (ptr_out !== 8'hFF) begin n_err++; $display("FAIL wrap_ptr255: got %h want ff", ptr_out); end
  endtask

  task automatic test_run();
    cpustate = 2'b11; cyc(1);
    n_cmp++; if (oob !== 1'b0) begin n_err++; $display("FAIL run_oob0: got %b want 0", oob); end
    addr = 16'h0010; data_in = 8'h5A; write = 1'b1; sb.push_back(8'h5A); cyc(1);
    write = 1'b0; read = 1'b1; cyc(1);
    read = 1'b0; exp_v = sb.pop_front();
    n_cmp++; if (data_out !== exp_v) begin n_err++; $display("FAIL run_raw: got %h want %h", data_out, exp_v); end
    addr = 16'h0110; read = 1'b1; sb.push_back(8'h00); cyc(1);
    read = 1'b0; exp_v = sb.pop_front();
    n_cmp++; if (data_out !== exp_v) begin n_err++; $display("FAIL run_oob_rd: got %h want %h", data_out, exp_v); end
    n_cmp++; if (oob !== 1'b1) begin n_err++; $display("FAIL run_oob: got %b want 1", oob); end
    addr = 16'h0010; read = 1'b1; sb.push_back(8'h5A); cyc(1);
    read = 1'b0; exp_v = sb.pop_front();
    n_cmp++; if (data_out !== exp_v) begin n_err++; $display("FAIL run_keep: got %h want %h", data_out, exp_v); end
    n_cmp++; if (ptr_out !== 8'hFF) begin n_err++; $display("FAIL run_ptr_hold: got %h want ff", ptr_out); end
    n_cmp++; if (check_out !== 8'hFF) begin n_err++; $display("FAIL run_chk_hold: got %h want ff", check_out); end
  endtask

  task automatic test_conflict();
    addr = 16'h0020; data_in = 8'h77; read = 1'b1; write = 1'b1; sb.push_back(8'h5A); cyc(1);
    read = 1'b0; write = 1'b0; exp_v = sb.pop_front();
    n_cmp++; if (conflict !== 1'b1) begin n_err++; $display("FAIL cf_flag: got %b want 1", conflict); end
    n_cmp++; if (data_out !== exp_v) begin n_err++; $display("FAIL cf_hold: got %h want %h", data_out, exp_v); end
    read = 1'b1; sb.push_back(8'h77); cyc(1);
    read = 1'b0; exp_v = sb.pop_front();
    n_cmp++; if (data_out !== exp_v) begin n_err++; $display("FAIL cf_wr: got %h want %h", data_out, exp_v); end
    cpustate = 2'b00; data_in = 8'h11; write = 1'b1; read = 1'b1; sb.push_back(8'h77); cyc(2);
    write = 1'b0; read = 1'b0;
    n_cmp++; if (data_out !== 8'h77) begin n_err++; $display("FAIL stop_dout: got %h want 77", data_out); end
    cpustate = 2'b11; read = 1'b1; cyc(1);
    read = 1'b0; exp_v = sb.pop_front();
    n_cmp++; if (data_out !== exp_v) begin n_err++; $display("FAIL stop_mem: got %h want %h", data_out, exp_v); end
  endtask

  task automatic test_key_hold();
    cpustate = 2'b01; cyc(2);
    D = 8'h99; A1 = 1'b1; cyc(20);
    A1 = 1'b0; cyc(3);
    n_cmp++; if (ptr_out !== 8'd1) begin n_err++; $display("FAIL hold_ptr: got %h want 01", ptr_out); end
    n_cmp++; if (check_out !== 8'h99) begin n_err++; $display("FAIL hold_chk: got %h want 99", check_out); end
    D = 8'h42; A1 = 1'b1; cyc(1);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (ptr_out !== 8'h00) begin n_err++; $display("FAIL abort_ptr: got %h want 00", ptr_out); end
    n_cmp++; if (check_out !== 8'h00) begin n_err++; $display("FAIL abort_chk: got %h want 00", check_out); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL abort_dout: got %h want 00", data_out); end
    n_cmp++; if ({oob, conflict} !== 2'b00) begin n_err++; $display("FAIL abort_flags: got %b want 00", {oob, conflict}); end
    cyc(2); A1 = 1'b0; cyc(2);
    rst = 1'b1; cyc(6);
    n_cmp++; if (ptr_out !== 8'h00) begin n_err++; $display("FAIL post_ptr: got %h want 00", ptr_out); end
    n_cmp++; if (check_out !== 8'h00) begin n_err++; $display("FAIL post_chk: got %h want 00", check_out); end
    cpustate = 2'b10; sb.push_back(8'h00); cyc(3);
    exp_v = sb.pop_front();
    n_cmp++; if (check_out !== exp_v) begin n_err++; $display("FAIL post_mem0: got %h want %h", check_out, exp_v); end
  endtask

  initial begin
    rst = 1'b0; cpustate = 2'b00; addr = 16'h0000; data_in = 8'h00;
    read = 1'b0; write = 1'b0; A1 = 1'b0; D = 8'h00;
    cyc(2);
    test_reset();
    test_load_check();
    test_wrap();
    test_run();
    test_conflict();
    test_key_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-wide memory responder on the far end of the CPU's memory bus: it answers the CPU's `read`/`write` strobes against a 256-byte store while the machine is running, and serves the front-panel program-load and memory-check modes driven by `cpustate`, `D` and key `A1`. It sits between the CPU core and the display logic. It supplies `data_out` to the CPU data input and `check_out`/`ptr_out` to the seven-segment driver.

## Interface
- `DEPTH`, 256: number of bytes; address decode uses `addr[7:0]`, fixed at 256 in this revision.
- `clk` input 1: single system clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cpustate` input 2: mode; 2'b00 STOP, 2'b01 LOAD, 2'b10 CHECK, 2'b11 RUN.
- `addr` input 16: CPU address.
- `data_in` input 8: CPU write data.
- `read` input 1: CPU read strobe, level, active-high.
- `write` input 1: CPU write strobe, level, active-high.
- `A1` input 1: front-panel step key, asynchronous, active-high.
- `D` input 8: front-panel data switches.
- `data_out` output 8: read data to CPU.
- `check_out` output 8: byte shown on the display in LOAD/CHECK.
- `ptr_out` output 8: current load/check pointer.
- `oob` output 1: sticky; a RUN access hit `addr[15:8] != 0`.
- `conflict` output 1: sticky; a RUN cycle had `read` and `write` both high.

## Operation
- Reset (`rst`=0): all 256 bytes cleared to 8'h00. `data_out`, `check_out` and `ptr_out` are 8'h00. `oob` and `conflict` are 0. Key synchroniser is cleared and the previous-mode register is set to STOP.
- Key path: three flops a1_s1→a1_s2→a1_s3. `step` = a1_s2 & ~a1_s3, a one-cycle pulse per rising edge of A1. Holding A1 high yields exactly one step.
- Mode entry: `prev_mode` is registered each cycle. A change into LOAD or CHECK sets `ptr_out` to 0 on that edge, and any `step` in the same cycle is ignored.
- STOP: no memory writes. All outputs hold.
- LOAD: on `step`, mem[ptr_out] <= D, `check_out` <= D, `ptr_out` <= ptr_out+1 (mod 256; 255→0). CPU strobes are ignored.
- CHECK: each cycle `check_out` <= mem[ptr_out]. On `step`, `ptr_out` <= ptr_out+1 (mod 256), and `check_out` follows on the next cycle. CPU strobes are ignored.
- RUN: front-panel path ignored, `ptr_out` and `check_out` hold.
  - `write` with `addr[15:8]==0`: mem[addr[7:0]] <= data_in.
  - `read` alone with `addr[15:8]==0`: `data_out` <= mem[addr[7:0]].
  - `read` out of range: `data_out` <= 8'h00 and `oob` is set.
  - `write` out of range: no store and `oob` is set.
  - `read` & `write` together: write performed (with range rule), `data_out` holds, `conflict` is set.
  - Neither strobe: `data_out` holds.
- `oob` and `conflict` clear only on reset.
- Reset mid-operation: an asynchronous assertion aborts any write in progress; the addressed byte reads 0 after reset.

## Timing
- RUN read latency: 1 cycle. `data_out` is valid after the first rising edge with `read`=1. Read-after-write to the same address on the next cycle returns the new data.
- Write: committed at the rising edge where `write`=1.
- Key: with A1 rising before edge k, `step` is high between edges k+1 and k+2, and the LOAD write or pointer increment commits at edge k+2. A1 must stay high ≥3 cycles and low ≥3 cycles between presses.
- CHECK display: `check_out` reflects `ptr_out` one cycle after the pointer changes.
- Mode switches take effect at the edge where the new `cpustate` is sampled.

## Test plan
- Reset: hold `rst`=0, toggle strobes and A1. Required: all outputs are 0; in CHECK mode, stepping through 256 bytes shows 8'h00 everywhere.
- LOAD/CHECK: in LOAD, press A1 three times with D=8'hA5, 8'h3C, 8'hFF. Required: `ptr_out` is 3 and `check_out`=8'hFF. Switch to CHECK. Required: `ptr_out`=0 and `check_out`=8'hA5; after one press `ptr_out`=1 and `check_out`=8'h3C.
- Wrap: in LOAD, press 257 times with D equal to press index[7:0]. Required: `ptr_out`=1 and mem[0]=8'h00 (the 257th press overwrote it); CHECK at pointer 255 shows 8'hFF.
- RUN access: write 8'h5A to addr 16'h0010, then read 16'h0010 on the next cycle. Required: `data_out`=8'h5A one cycle later. Read 16'h0110. Required: `data_out`=8'h00, `oob`=1, and mem[8'h10] still 8'h5A.
- Conflict: in RUN, `read`=`write`=1, addr 16'h0020, data_in 8'h77. Required: `conflict`=1, `data_out` unchanged, and a later read returns 8'h77. Strobes asserted in STOP leave memory unchanged.
- Key hold/abort: hold A1 high for 20 cycles in LOAD. Required: exactly one write. Assert `rst` mid-hold. Required: immediate zero outputs and no further write after release.
